// File: rtl/pcie_link_ctrl.sv
// rtl/pcie_link_ctrl.sv - reduced LTSSM link-training sequencer for pcie_phys_top
//
// Purpose:
//   Walks DETECT_QUIET -> DETECT_ACTIVE -> POLLING -> CONFIG -> L0, with a
//   RECOVERY loop used for lock loss and the 8b/10b -> 128b/130b speed change.
//   Drives per-lane transmit enables and the encoding selects, and gates the
//   MAC frame handshake so frames pass only while the link is up.
//
// Ports:
//   clk_i, rst_ni            core clock, asynchronous active-low reset
//   lane_detected_i          per-lane receiver-detect result (level)
//   rx_lock_i                per-lane symbol/block lock (level)
//   gen3_supported_i         both ends support 128b/130b
//   speed_change_req_i       request for 128b/130b, honoured only in L0
//   mac_data_frame_valid_i   MAC frame valid
//   phy_tx_ready_i           PHY datapath can take a frame
//   mac_data_frame_ready_o   link_up_o & phy_tx_ready_i (combinational)
//   lane_enable_o            per-lane transmit enable
//   link_width_o             negotiated lane count (0, 1, 2, 4, ...)
//   en8b10b_o, en128b130b_o  one-hot encoding select
//   link_up_o                high only in L0
//   state_o                  current state code
//   frame_accept_o           valid & ready handshake this cycle (combinational)

module pcie_link_ctrl #(
  parameter int NUM_LANES     = 4,
  parameter int QUIET_CYCLES  = 16,
  parameter int LOCK_CYCLES   = 8,
  parameter int POLL_TIMEOUT  = 1024,
  parameter int RECOV_TIMEOUT = 256
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NUM_LANES-1:0]        lane_detected_i,
  input  logic [NUM_LANES-1:0]        rx_lock_i,
  input  logic                        gen3_supported_i,
  input  logic                        speed_change_req_i,
  input  logic                        mac_data_frame_valid_i,
  input  logic                        phy_tx_ready_i,
  output logic                        mac_data_frame_ready_o,
  output logic [NUM_LANES-1:0]        lane_enable_o,
  output logic [$clog2(NUM_LANES):0]  link_width_o,
  output logic                        en8b10b_o,
  output logic                        en128b130b_o,
  output logic                        link_up_o,
  output logic [2:0]                  state_o,
  output logic                        frame_accept_o
);

  localparam int WW      = $clog2(NUM_LANES) + 1;
  localparam int CNT_MAX = (POLL_TIMEOUT > RECOV_TIMEOUT)
                         ? ((POLL_TIMEOUT > QUIET_CYCLES) ? POLL_TIMEOUT : QUIET_CYCLES)
                         : ((RECOV_TIMEOUT > QUIET_CYCLES) ? RECOV_TIMEOUT : QUIET_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int LCK_W   = $clog2(LOCK_CYCLES + 1);

  localparam logic [CNT_W-1:0] QUIET_LIM = CNT_W'(QUIET_CYCLES);
  localparam logic [CNT_W-1:0] POLL_LIM  = CNT_W'(POLL_TIMEOUT);
  localparam logic [CNT_W-1:0] RECOV_LIM = CNT_W'(RECOV_TIMEOUT);
  localparam logic [LCK_W-1:0] LOCK_LIM  = LCK_W'(LOCK_CYCLES);

  localparam logic [2:0] ST_DETECT_QUIET  = 3'd0;
  localparam logic [2:0] ST_DETECT_ACTIVE = 3'd1;
  localparam logic [2:0] ST_POLLING       = 3'd2;
  localparam logic [2:0] ST_CONFIG        = 3'd3;
  localparam logic [2:0] ST_L0            = 3'd4;
  localparam logic [2:0] ST_RECOVERY      = 3'd5;

  // State and counters
  logic [2:0]           state_q, state_d;
  logic [LCK_W-1:0]     lock_cnt_q, lock_cnt_d;
  logic [CNT_W-1:0]     tmo_cnt_q, tmo_cnt_d;

  // Registered outputs and sideband state
  logic [NUM_LANES-1:0] det_mask_q, det_mask_d;
  logic [NUM_LANES-1:0] lane_en_q, lane_en_d;
  logic [WW-1:0]        width_q, width_d;
  logic                 en8_q, en8_d;
  logic                 en128_q, en128_d;
  logic                 link_up_q, link_up_d;
  logic                 pend_q, pend_d;

  // Decoded conditions
  logic                 all_locked;
  logic                 lock_lost;
  logic                 speed_req;
  logic [LCK_W-1:0]     lock_nxt;
  logic [CNT_W-1:0]     tmo_nxt;
  logic [CNT_W-1:0]     tmo_lim;
  logic [WW-1:0]        cfg_width;
  logic [NUM_LANES-1:0] cfg_mask;

  function automatic logic [NUM_LANES-1:0] low_ones(input int n);
    logic [NUM_LANES-1:0] m;
    m = '0;
    for (int b = 0; b < NUM_LANES; b++) begin
      if (b < n) m[b] = 1'b1;
    end
    return m;
  endfunction

  // Widest power-of-two prefix of detected lanes. A wider prefix implies every
  // narrower one, so the last match in the ascending scan is the answer.
  always_comb begin
    cfg_width = '0;
    cfg_mask  = '0;
    for (int i = 0; i < WW; i++) begin
      if ((det_mask_q & low_ones(1 << i)) == low_ones(1 << i)) begin
        cfg_width = WW'(1 << i);
        cfg_mask  = low_ones(1 << i);
      end
    end
  end

  // Only lanes currently enabled take part in the lock decision.
  assign all_locked = &(rx_lock_i | ~lane_en_q);
  assign lock_lost  = |(lane_en_q & ~rx_lock_i);
  assign speed_req  = speed_change_req_i & gen3_supported_i & en8_q;
  assign lock_nxt   = all_locked ? (lock_cnt_q + LCK_W'(1)) : '0;
  assign tmo_nxt    = tmo_cnt_q + CNT_W'(1);
  assign tmo_lim    = (state_q == ST_RECOVERY) ? RECOV_LIM : POLL_LIM;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_DETECT_QUIET;
      lock_cnt_q <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    case (state_q)
      ST_DETECT_QUIET: begin
        tmo_cnt_d = tmo_nxt;
        if (tmo_nxt == QUIET_LIM) state_d = ST_DETECT_ACTIVE;
      end
      ST_DETECT_ACTIVE: begin
        state_d = (|lane_detected_i) ? ST_POLLING : ST_DETECT_QUIET;
      end
      ST_POLLING, ST_RECOVERY: begin
        lock_cnt_d = lock_nxt;
        tmo_cnt_d  = tmo_nxt;
        // Lock is tested first so it wins a same-cycle timeout.
        if (lock_nxt == LOCK_LIM) begin
          state_d = (state_q == ST_POLLING) ? ST_CONFIG : ST_L0;
        end else if (tmo_nxt == tmo_lim) begin
          state_d = ST_DETECT_QUIET;
        end
      end
      ST_CONFIG: begin
        state_d = (cfg_width == '0) ? ST_DETECT_QUIET : ST_L0;
      end
      ST_L0: begin
        if (lock_lost || speed_req) state_d = ST_RECOVERY;
      end
      default: state_d = ST_DETECT_QUIET;
    endcase
    // Every state starts with fresh lock and timeout counts.
    if (state_d != state_q) begin
      lock_cnt_d = '0;
      tmo_cnt_d  = '0;
    end
  end

  // Output next-value logic; outputs are registered so they line up with state_q.
  always_comb begin
    det_mask_d = det_mask_q;
    lane_en_d  = lane_en_q;
    width_d    = width_q;
    en8_d      = en8_q;
    en128_d    = en128_q;
    pend_d     = pend_q;
    link_up_d  = (state_d == ST_L0);
    case (state_q)
      ST_DETECT_ACTIVE: begin
        det_mask_d = lane_detected_i;
        if (state_d == ST_POLLING) lane_en_d = lane_detected_i;
      end
      ST_CONFIG: begin
        if (state_d == ST_L0) begin
          width_d   = cfg_width;
          lane_en_d = cfg_mask;
        end
      end
      ST_L0: begin
        if (speed_req) pend_d = 1'b1;
      end
      ST_RECOVERY: begin
        // Encoding swap coincides with re-entering L0.
        if (state_d == ST_L0 && pend_q) begin
          en8_d   = 1'b0;
          en128_d = 1'b1;
          pend_d  = 1'b0;
        end
      end
      default: ;
    endcase
    // Falling back to DETECT_QUIET tears the link down completely.
    if (state_d == ST_DETECT_QUIET && state_q != ST_DETECT_QUIET) begin
      lane_en_d = '0;
      width_d   = '0;
      en8_d     = 1'b1;
      en128_d   = 1'b0;
      pend_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      det_mask_q <= '0;
      lane_en_q  <= '0;
      width_q    <= '0;
      en8_q      <= 1'b1;
      en128_q    <= 1'b0;
      link_up_q  <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      det_mask_q <= det_mask_d;
      lane_en_q  <= lane_en_d;
      width_q    <= width_d;
      en8_q      <= en8_d;
      en128_q    <= en128_d;
      link_up_q  <= link_up_d;
      pend_q     <= pend_d;
    end
  end

  assign state_o                = state_q;
  assign lane_enable_o          = lane_en_q;
  assign link_width_o           = width_q;
  assign en8b10b_o              = en8_q;
  assign en128b130b_o           = en128_q;
  assign link_up_o              = link_up_q;
  assign mac_data_frame_ready_o = link_up_q & phy_tx_ready_i;
  assign frame_accept_o         = mac_data_frame_valid_i & mac_data_frame_ready_o;

endmodule

// File: doc/pcie_link_ctrl.md
Name: pcie_link_ctrl

Overview:
Link-training sequencer for pcie_phys_top, implemented as a reduced LTSSM. It detects receivers, waits for per-lane symbol lock, negotiates link width and selects the line encoding (8b/10b or 128b/130b). It drives the PHY lane enables and encoding selects, and gates the MAC frame handshake until the link is up. It sits between the MAC-side frame interface and the per-lane PHY datapath.

Parameters:
NUM_LANES, 4, number of physical lanes (power of two, 1..16)
QUIET_CYCLES, 16, cycles spent in DETECT_QUIET before each detect attempt
LOCK_CYCLES, 8, consecutive all-locked cycles required to leave POLLING or RECOVERY
POLL_TIMEOUT, 1024, cycles in POLLING before abandoning to DETECT_QUIET
RECOV_TIMEOUT, 256, cycles in RECOVERY before abandoning to DETECT_QUIET

Ports:
clk_i  in  1  core clock
rst_ni  in  1  asynchronous active-low reset
lane_detected_i  in  NUM_LANES  receiver-detect result per lane, level
rx_lock_i  in  NUM_LANES  per-lane symbol/block lock, level
gen3_supported_i  in  1  both link ends support 128b/130b
speed_change_req_i  in  1  request to move to 128b/130b, sampled in L0 only
mac_data_frame_valid_i  in  1  MAC frame valid
phy_tx_ready_i  in  1  PHY datapath can accept a frame
mac_data_frame_ready_o  out  1  combinational: link_up_o & phy_tx_ready_i
lane_enable_o  out  NUM_LANES  per-lane transmit enable
link_width_o  out  $clog2(NUM_LANES)+1  negotiated lane count (0, 1, 2, 4, ...)
en8b10b_o  out  1  select 8b/10b encoding
en128b130b_o  out  1  select 128b/130b encoding
link_up_o  out  1  high only in L0
state_o  out  3  current state code
frame_accept_o  out  1  pulse: valid & ready handshake this cycle

Behaviour:
- Reset (async assert, sync release): state=DETECT_QUIET, all counters 0, det_mask=0, link_width_o=0, lane_enable_o=0, en8b10b_o=1, en128b130b_o=0, link_up_o=0, speed_pending=0.
- All outputs except mac_data_frame_ready_o and frame_accept_o are registered. en8b10b_o and en128b130b_o are always mutually exclusive, and exactly one is high.
- State codes: DETECT_QUIET=0, DETECT_ACTIVE=1, POLLING=2, CONFIG=3, L0=4, RECOVERY=5. Codes 6 and 7 go to DETECT_QUIET on the next cycle.
- DETECT_QUIET:
  - Counts QUIET_CYCLES cycles, then enters DETECT_ACTIVE.
  - On entry: lane_enable_o=0, encoding forced to 8b/10b, speed_pending=0.
- DETECT_ACTIVE (1 cycle):
  - Latches det_mask=lane_detected_i.
  - If det_mask≠0, enter POLLING; otherwise return to DETECT_QUIET.
- POLLING:
  - lane_enable_o=det_mask.
  - all_locked = &(rx_lock_i | ~mask), where mask is the current lane_enable_o.
  - lock_cnt increments while all_locked and clears otherwise. timeout_cnt increments every cycle.
  - lock_cnt reaching LOCK_CYCLES moves to CONFIG.
  - timeout_cnt reaching POLL_TIMEOUT moves to DETECT_QUIET. If both happen in the same cycle, lock wins.
  - Both counters clear on every state entry.
- CONFIG (1 cycle):
  - width = largest power of two N ≤ NUM_LANES such that det_mask[N-1:0] is all ones.
  - If det_mask[0]=0 (width 0), go to DETECT_QUIET.
  - Otherwise set link_width_o=N and lane_enable_o to the low N bits set, then go to L0.
- L0:
  - link_up_o=1.
  - Leave to RECOVERY if any enabled lane drops lock.
  - Leave to RECOVERY if speed_change_req_i & gen3_supported_i & en8b10b_o; this also sets speed_pending.
  - If lock loss and a valid speed request occur in the same cycle, go to RECOVERY with speed_pending set.
  - A speed request when gen3_supported_i=0 or when already in 128b/130b is ignored.
- RECOVERY:
  - link_up_o=0. Lanes and width are unchanged.
  - Uses the same lock and timeout counters, with RECOV_TIMEOUT as the limit.
  - On reaching lock: go to L0. If speed_pending, swap to 128b/130b in the same cycle L0 is entered, then clear speed_pending.
  - On timeout: go to DETECT_QUIET, which resets width, lanes and encoding.
- Handshake: frame_accept_o = mac_data_frame_valid_i & mac_data_frame_ready_o. Ready drops in the same cycle link_up_o falls; no frame is accepted outside L0.
- Reset asserted mid-operation returns all outputs to reset values immediately (asynchronous).

Test Plan:
- Basic link-up: lane_detected_i=4'b1111, rx_lock_i=1111 after 3 cycles in POLLING -> CONFIG reached after 8 consecutive locked cycles; L0 with link_width_o=4, lane_enable_o=1111, en8b10b_o=1, mac_data_frame_ready_o follows phy_tx_ready_i.
- Partial detect: lane_detected_i=4'b1011 -> link_width_o=2, lane_enable_o=0011. lane_detected_i=4'b1110 -> CONFIG returns to DETECT_QUIET, link_up_o never asserts.
- Lock glitch and timeout: lock drops for 1 cycle at lock_cnt=7 -> counter restarts. Lock never held for 8 cycles -> DETECT_QUIET exactly 1024 cycles after POLLING entry.
- Speed change: in L0 with gen3_supported_i=1, pulse speed_change_req_i -> RECOVERY with link_up_o=0; after 8 locked cycles -> L0 with en128b130b_o=1, en8b10b_o=0. Repeat the same request with gen3_supported_i=0 -> stays in L0.
- Lock loss in L0: drop rx_lock_i[1] -> RECOVERY next cycle and frame_accept_o=0 while valid stays high. Lock never restored -> DETECT_QUIET after 256 cycles, with encoding back to 8b/10b and link_width_o=0.
- Async reset in L0 mid-frame: deassert rst_ni -> state_o=0, lane_enable_o=0 and link_up_o=0 with no clock edge required.
